// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory between the instruction-fetch port and the
// MEM-stage data port of a pipelined core. One transaction is in flight at a
// time: IDLE arbitrates, GNT_I / GNT_D hold the request on the memory until it
// acks (or the wait counter times out), and RESP pulses the winner's ack.
// The data port normally wins, but a fetch that has been passed over
// STARVE_LIMIT times in a row is served next.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   i_req_i, i_addr_i     fetch read request and address
//   i_ack_o, i_rdata_o    fetch completion pulse and read data
//   d_req_i, d_we_i       data request, 1 = write
//   d_addr_i, d_wdata_i   data address and write data
//   d_ack_o, d_rdata_o    data completion pulse and read data
//   mem_req_o, mem_we_o   request / write enable to the shared memory
//   mem_addr_o            memory address
//   mem_wdata_o           memory write data
//   mem_ack_i             one-cycle memory completion, read data valid with it
//   mem_rdata_i           memory read data
//   stall_o               pipeline stall while any request is unanswered
//   err_o                 sticky error: timeout or stray memory ack
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic          i_ack_o,
    output logic [DW-1:0] i_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ack_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          stall_o,
    output logic          err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q,     state_d;
    logic [SW-1:0]   starveCnt_q, starveCnt_d;
    logic [WW-1:0]   waitCnt_q,   waitCnt_d;
    logic [AW-1:0]   addr_q,      addr_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic            we_q,        we_d;
    logic            isData_q,    isData_d;
    logic [DW-1:0]   iRdata_q,    iRdata_d;
    logic [DW-1:0]   dRdata_q,    dRdata_d;
    logic            err_q,       err_d;
    logic            inGrant;

    assign inGrant = (state_q == GNT_I) || (state_q == GNT_D);

    // State register. Reset abandons whatever transaction is in flight without
    // an ack; any memory ack that still arrives is then treated as stray.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            starveCnt_q <= '0;
            waitCnt_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            isData_q    <= 1'b0;
            iRdata_q    <= '0;
            dRdata_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            waitCnt_q   <= waitCnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            isData_q    <= isData_d;
            iRdata_q    <= iRdata_d;
            dRdata_q    <= dRdata_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic. Arbitration happens only in IDLE, so requests seen
    // during RESP wait one more cycle. The winner's address, write enable and
    // write data are latched on grant entry so the memory sees stable values
    // even if the requester drops its request early. A memory ack outside a
    // grant never touches data or state, it only raises the sticky error.
    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        waitCnt_d   = waitCnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        isData_d    = isData_q;
        iRdata_d    = iRdata_q;
        dRdata_d    = dRdata_q;
        err_d       = err_q | (mem_ack_i & ~inGrant);

        case (state_q)
            IDLE: begin
                if (d_req_i && !(i_req_i && (starveCnt_q == STARVE_MAX))) begin
                    state_d   = GNT_D;
                    addr_d    = d_addr_i;
                    we_d      = d_we_i;
                    wdata_d   = d_wdata_i;
                    isData_d  = 1'b1;
                    waitCnt_d = '0;
                    if (i_req_i && (starveCnt_q != STARVE_MAX)) begin
                        starveCnt_d = starveCnt_q + 1'b1;
                    end
                end else if (i_req_i) begin
                    state_d     = GNT_I;
                    addr_d      = i_addr_i;
                    we_d        = 1'b0;
                    wdata_d     = '0;
                    isData_d    = 1'b0;
                    waitCnt_d   = '0;
                    starveCnt_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ack_i) begin
                    state_d = RESP;
                    if (isData_q) begin
                        dRdata_d = mem_rdata_i;
                    end else begin
                        iRdata_d = mem_rdata_i;
                    end
                end else if (waitCnt_q == WAIT_MAX) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (isData_q) begin
                        dRdata_d = '0;
                    end else begin
                        iRdata_d = '0;
                    end
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_o   = inGrant;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign i_ack_o     = (state_q == RESP) && !isData_q;
    assign d_ack_o     = (state_q == RESP) && isData_q;
    assign i_rdata_o   = iRdata_q;
    assign d_rdata_o   = dRdata_q;
    assign err_o       = err_q;
    assign stall_o     = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with default parameters. Each transaction
// pushes its hand-computed response onto a queue; a monitor pops and compares
// whenever either ack pulses. A small memory model answers grants after a
// configurable number of wait cycles, returning a fixed word per address.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk_i;
    logic          rst_i;
    logic          i_req_i;
    logic [AW-1:0] i_addr_i;
    logic          i_ack_o;
    logic [DW-1:0] i_rdata_o;
    logic          d_req_i;
    logic          d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_ack_o;
    logic [DW-1:0] d_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;
    logic          stall_o;
    logic          err_o;

    typedef struct packed {
        logic        isData;
        logic [31:0] rdata;
    } resp_t;

    resp_t expQ[$];
    int    errors    = 0;
    int    checks    = 0;
    int    memDelay  = 0;
    bit    memEnable = 1'b1;
    bit    forceAck  = 1'b0;

    mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(64)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i),
        .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    // 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Contents of the modelled memory; writes do not modify it.
    function automatic logic [31:0] memRead(input logic [31:0] addr);
        case (addr)
            32'h40:  return 32'h8C22_0004;
            32'h10:  return 32'h1111_0010;
            32'h20:  return 32'h2222_0020;
            32'h30:  return 32'h3333_0030;
            32'h60:  return 32'h6666_0060;
            32'h70:  return 32'h7777_0070;
            default: return 32'hBAD0_0000;
        endcase
    endfunction

    // Memory model: answers a held mem_req_o after memDelay extra grant
    // cycles. forceAck injects an ack regardless of any request.
    initial begin
        int cnt;
        cnt         = 0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_ack_i   = 1'b0;
            mem_rdata_i = '0;
            if (forceAck) begin
                mem_ack_i = 1'b1;
            end else if (mem_req_o && memEnable) begin
                if (cnt >= memDelay) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = memRead(mem_addr_o);
                    cnt         = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every ack pulse must match the oldest expected response in
    // port and read data.
    initial begin
        resp_t       exp;
        logic [31:0] act;
        forever begin
            @(negedge clk_i);
            if (i_ack_o || d_ack_o) begin
                checks++;
                act = d_ack_o ? d_rdata_o : i_rdata_o;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_ack: i_ack=%0b d_ack=%0b rdata=0x%0h, no response expected",
                             i_ack_o, d_ack_o, act);
                end else begin
                    exp = expQ.pop_front();
                    if ((i_ack_o && d_ack_o) || (d_ack_o != exp.isData) || (act != exp.rdata)) begin
                        errors++;
                        $display("[TB] FAIL response: got i_ack=%0b d_ack=%0b rdata=0x%0h, expected port=%s rdata=0x%0h",
                                 i_ack_o, d_ack_o, act, exp.isData ? "data" : "fetch", exp.rdata);
                    end
                end
            end
        end
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic isData, input logic [31:0] rdata);
        resp_t e;
        e.isData = isData;
        e.rdata  = rdata;
        expQ.push_back(e);
    endtask

    task automatic resetDut(input int n);
        rst_i = 1'b1;
        repeat (n) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One transaction on one port. While the grant is up the latched memory
    // command is checked every cycle; the ack must appear delay+2 negedges
    // after the request is raised (grant, delay wait cycles, ack, RESP).
    task automatic applyStimulus(input logic isData, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int delay, input logic [31:0] expRdata,
                                 input bit dropEarly);
        int cycles;
        bit seen;
        pushExp(isData, expRdata);
        memDelay  = delay;
        memEnable = 1'b1;
        if (isData) begin
            d_we_i    = we;
            d_addr_i  = addr;
            d_wdata_i = wdata;
            d_req_i   = 1'b1;
        end else begin
            i_addr_i  = addr;
            i_req_i   = 1'b1;
        end
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clk_i);
            cycles++;
            if (dropEarly && cycles == 1) begin
                d_req_i = 1'b0;
                i_req_i = 1'b0;
            end
            if (mem_req_o) begin
                checkOutput("mem_we", {31'd0, mem_we_o}, {31'd0, isData ? we : 1'b0});
                checkOutput("mem_addr", mem_addr_o, addr);
                if (isData) checkOutput("mem_wdata", mem_wdata_o, wdata);
            end
            if (isData ? d_ack_o : i_ack_o) seen = 1'b1;
        end
        checkOutput("ack_latency", cycles, delay + 2);
        d_req_i = 1'b0;
        i_req_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        int cycles, dAt, iAt, dCount, grantCycles;
        bit iSeen, dSeen;

        rst_i     = 1'b1;
        i_req_i   = 1'b0;
        i_addr_i  = '0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        d_addr_i  = '0;
        d_wdata_i = '0;

        // Reset values.
        repeat (3) @(negedge clk_i);
        checkOutput("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("rst_i_ack", {31'd0, i_ack_o}, 32'd0);
        checkOutput("rst_d_ack", {31'd0, d_ack_o}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_i_rdata", i_rdata_o, 32'd0);
        checkOutput("rst_d_rdata", d_rdata_o, 32'd0);
        checkOutput("rst_err", {31'd0, err_o}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Fetch, memory acks in first grant cycle.
        applyStimulus(1'b0, 1'b0, 32'h40, 32'h0, 0, 32'h8C22_0004, 1'b0);
        // Data write held stable for a slow memory.
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3, 32'h1111_0010, 1'b0);
        // Data read.
        applyStimulus(1'b1, 1'b0, 32'h60, 32'h0, 0, 32'h6666_0060, 1'b0);
        // Request dropped right after grant: the ack still comes.
        applyStimulus(1'b1, 1'b0, 32'h70, 32'h0, 2, 32'h7777_0070, 1'b1);
        checkOutput("err_clean", {31'd0, err_o}, 32'd0);

        // Both ports request together, memory acks in the second grant cycle:
        // data first (ack 3 negedges in), then fetch (7 negedges in).
        pushExp(1'b1, 32'h3333_0030);
        pushExp(1'b0, 32'h2222_0020);
        memDelay = 1;
        i_addr_i = 32'h20;
        d_addr_i = 32'h30;
        d_we_i   = 1'b0;
        i_req_i  = 1'b1;
        d_req_i  = 1'b1;
        cycles = 0; dAt = 0; iAt = 0; iSeen = 1'b0; dSeen = 1'b0;
        while (!iSeen && cycles < 100) begin
            @(negedge clk_i);
            cycles++;
            if (!i_ack_o) checkOutput("stall_both", {31'd0, stall_o}, 32'd1);
            if (d_ack_o) begin
                dAt     = cycles;
                dSeen   = 1'b1;
                d_req_i = 1'b0;
            end
            if (i_ack_o) begin
                iAt     = cycles;
                iSeen   = 1'b1;
                i_req_i = 1'b0;
            end
        end
        checkOutput("both_d_ack_cycle", dAt, 3);
        checkOutput("both_i_ack_cycle", iAt, 7);
        @(negedge clk_i);

        // Starvation: data held continuously with fetch waiting ->
        // four data grants, then the fetch.
        repeat (4) pushExp(1'b1, 32'h3333_0030);
        pushExp(1'b0, 32'h2222_0020);
        memDelay = 0;
        i_addr_i = 32'h20;
        d_addr_i = 32'h30;
        i_req_i  = 1'b1;
        d_req_i  = 1'b1;
        cycles = 0; dCount = 0; iSeen = 1'b0;
        while (!iSeen && cycles < 200) begin
            @(negedge clk_i);
            cycles++;
            if (d_ack_o) dCount++;
            if (i_ack_o) iSeen = 1'b1;
        end
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        checkOutput("starve_fetch_served", {31'd0, iSeen}, 32'd1);
        checkOutput("starve_data_grants", dCount, 4);
        @(negedge clk_i);
        checkOutput("starve_cnt_after", {29'd0, dut.starveCnt_q}, 32'd0);

        // Memory never answers: 64 grant cycles, ack with zero data, err set.
        pushExp(1'b1, 32'h0);
        memEnable = 1'b0;
        d_addr_i  = 32'h60;
        d_we_i    = 1'b0;
        d_req_i   = 1'b1;
        cycles = 0; grantCycles = 0; dSeen = 1'b0;
        while (!dSeen && cycles < 300) begin
            @(negedge clk_i);
            cycles++;
            if (mem_req_o) grantCycles++;
            if (d_ack_o) dSeen = 1'b1;
        end
        d_req_i = 1'b0;
        checkOutput("timeout_grant_cycles", grantCycles, 64);
        checkOutput("timeout_err", {31'd0, err_o}, 32'd1);
        @(negedge clk_i);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 0, 32'h2222_0020, 1'b0);
        checkOutput("err_sticky", {31'd0, err_o}, 32'd1);
        resetDut(2);
        checkOutput("err_cleared", {31'd0, err_o}, 32'd0);
        checkOutput("rst2_i_rdata", i_rdata_o, 32'd0);
        checkOutput("rst2_d_rdata", d_rdata_o, 32'd0);

        // Reset during a fetch grant, then a stray memory ack.
        memEnable = 1'b0;
        i_addr_i  = 32'h20;
        i_req_i   = 1'b1;
        cycles = 0;
        while (!mem_req_o && cycles < 10) begin
            @(negedge clk_i);
            cycles++;
        end
        checkOutput("grant_before_reset", {31'd0, mem_req_o}, 32'd1);
        rst_i   = 1'b1;
        i_req_i = 1'b0;
        @(negedge clk_i);
        rst_i   = 1'b0;
        checkOutput("reset_drops_req", {31'd0, mem_req_o}, 32'd0);
        forceAck = 1'b1;
        repeat (2) @(negedge clk_i);
        forceAck = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("stray_no_req", {31'd0, mem_req_o}, 32'd0);
            checkOutput("stray_no_i_ack", {31'd0, i_ack_o}, 32'd0);
            checkOutput("stray_err", {31'd0, err_o}, 32'd1);
        end
        memEnable = 1'b1;

        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
